// File: rtl/serial_byte_receiver_pkg.sv
// Shared constants and state encoding for the serial byte link (transmitter and receiver).
// Frame layout: DEPTH bytes of DATA_W bits, MSB first, address order 0..DEPTH-1.
package serial_byte_receiver_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_byte_receiver_if.sv
// Serial receive side bundle: bit stream in, completed-byte strobe and read port out.
// Optional checksum output is present when SERIAL_RX_CHECKSUM_EN is defined.
interface serial_byte_receiver_if;
    import serial_byte_receiver_pkg::*;

    logic              start;
    logic              bit_en;
    logic              serial_in;
    logic [DATA_W-1:0] byte_out;
    logic              byte_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic              frame_done;
    logic              busy;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
`ifdef SERIAL_RX_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    // Driver side of the link plus the reader of the memory port.
    modport master (
        output start, bit_en, serial_in, rd_addr,
`ifdef SERIAL_RX_CHECKSUM_EN
        input  checksum,
`endif
        input  byte_out, byte_valid, wr_addr, frame_done, busy, rd_data
    );

    modport slave (
        input  start, bit_en, serial_in, rd_addr,
`ifdef SERIAL_RX_CHECKSUM_EN
        output checksum,
`endif
        output byte_out, byte_valid, wr_addr, frame_done, busy, rd_data
    );

endinterface

// File: rtl/serial_byte_receiver_rx_shift_reg.sv
// Serial-in/parallel-out register: shifts MSB first, pulses done the cycle after the W-th bit.
// restart realigns the bit counter; a bit sampled together with restart is bit 0 of a new word.
module rx_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         restart,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] data,
    output logic         done
);
    localparam int CNT_W = $clog2(W);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            data <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (en) begin
                data <= {data[W-2:0], din};
                if (restart) begin
                    cnt <= CNT_W'(1);
                end else if (cnt == CNT_W'(W - 1)) begin
                    cnt  <= '0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else if (restart) begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/serial_byte_receiver.sv
// Receive end of the MSB-first serial byte link; stores one DEPTH-byte frame in local memory.
// Define SERIAL_RX_CHECKSUM_EN to add a running XOR checksum of the bytes written since start.
module serial_byte_receiver
    import serial_byte_receiver_pkg::*;
(
    input  logic                   clk,
    input  logic                   clear,
    serial_byte_receiver_if.slave  rx,
    output state_t                 dbg_state
);

    state_t            state;
    logic [ADDR_W-1:0] byte_cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] sr_data;
    logic              sr_done;
    logic              sample;
`ifdef SERIAL_RX_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    // Bits are taken while receiving, and also on the start cycle itself.
    assign sample = rx.bit_en && (rx.start || (state == RECV));

    rx_shift_reg #(.W(DATA_W)) u_shift (
        .clk     (clk),
        .clear   (clear),
        .restart (rx.start),
        .en      (sample),
        .din     (rx.serial_in),
        .data    (sr_data),
        .done    (sr_done)
    );

    // The shift register holds the completed byte for one cycle; commit it on the following edge.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state         <= IDLE;
            byte_cnt      <= '0;
            rx.byte_out   <= '0;
            rx.byte_valid <= 1'b0;
            rx.wr_addr    <= '0;
            rx.frame_done <= 1'b0;
            rx.busy       <= 1'b0;
`ifdef SERIAL_RX_CHECKSUM_EN
            csum          <= '0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            rx.byte_valid <= 1'b0;
            if (rx.start) begin
                state         <= RECV;
                byte_cnt      <= '0;
                rx.frame_done <= 1'b0;
                rx.busy       <= 1'b1;
`ifdef SERIAL_RX_CHECKSUM_EN
                csum          <= '0;
`endif
            end else if (state == RECV && sr_done) begin
                mem[byte_cnt] <= sr_data;
                rx.byte_out   <= sr_data;
                rx.wr_addr    <= byte_cnt;
                rx.byte_valid <= 1'b1;
                byte_cnt      <= byte_cnt + ADDR_W'(1);
`ifdef SERIAL_RX_CHECKSUM_EN
                csum          <= csum ^ sr_data;
`endif
                if (byte_cnt == ADDR_W'(DEPTH - 1)) begin
                    state         <= DONE;
                    rx.busy       <= 1'b0;
                    rx.frame_done <= 1'b1;
                end
            end
        end
    end

    assign rx.rd_data = mem[rx.rd_addr];
    assign dbg_state  = state;
`ifdef SERIAL_RX_CHECKSUM_EN
    assign rx.checksum = csum;
`endif

endmodule

// File: doc/serial_byte_receiver.md
Name: serial_byte_receiver

Overview:
- Receive end of the bit-serial byte stream that the memory-to-serial transmitter produces: MSB-first, 8 bits per byte, bytes in address order 0..15.
- Deserialises the stream into bytes and writes them into a local 16x8 memory.
- Memory is readable through a combinational read port.
- Flags per-byte completion and whole-frame completion; sits at the link's receive side, clocked at the bit rate.

Parameters:
- DATA_W, 8, bits per byte / memory word width
- DEPTH, 16, bytes per frame / memory entries
- ADDR_W, 4, address width, equals log2(DEPTH)

Ports:
- clk  input  1  bit clock, rising edge active
- clear  input  1  asynchronous active-low reset
- start  input  1  frame-start pulse, aligns bit 0 of byte 0 to the same cycle
- bit_en  input  1  serial_in holds a valid bit this cycle
- serial_in  input  1  serial data, MSB of each byte first
- byte_out  output  DATA_W  last completed byte
- byte_valid  output  1  one-cycle pulse, byte_out/wr_addr updated
- wr_addr  output  ADDR_W  address the last completed byte was written to
- frame_done  output  1  high once DEPTH bytes are received; held until next start
- busy  output  1  high in RECV
- rd_addr  input  ADDR_W  read address
- rd_data  output  DATA_W  combinational mem[rd_addr]

Behaviour:
- Reset (clear=0, async): state IDLE; bit_cnt=0, byte_cnt=0, shift=0; byte_out=0, byte_valid=0, wr_addr=0, frame_done=0, busy=0; all memory entries 0.
- States:
  - IDLE: start=1 -> RECV.
  - RECV: byte_cnt reaches DEPTH -> DONE.
  - DONE: start=1 -> RECV.
- start handling:
  - start=1 in any state clears bit_cnt, byte_cnt and frame_done.
  - If bit_en=1 in the same cycle, that bit is sampled as bit 7 of byte 0.
- RECV, bit_en=1: shift <= {shift[DATA_W-2:0], serial_in}; bit_cnt increments.
- RECV, bit_en=0: hold all state; no timeout.
- Byte completion, on the cycle the 8th bit is sampled (bit_cnt==7 && bit_en):
  - mem[byte_cnt] <= completed byte; byte_out <= completed byte; wr_addr <= byte_cnt.
  - byte_valid=1 for exactly one cycle, visible the cycle after the 8th bit.
  - bit_cnt wraps to 0; byte_cnt increments.
- Latency: 8th bit sampled at edge N -> byte_valid, byte_out and mem updated after edge N+1.
- Last byte: when byte_cnt==DEPTH-1 completes, go to DONE.
  - frame_done=1 and busy=0 after the same edge as that byte's byte_valid.
- DONE: serial_in and bit_en ignored; memory frozen.
- start mid-frame (RECV): abort.
  - Partial byte discarded; already-written bytes kept.
  - Reception restarts at address 0.
- start on the same cycle as an 8th bit: start wins; the partial byte is not written.
- clear mid-frame: immediate asynchronous return to reset values, including memory.
- rd_data is combinational from rd_addr at all times.
  - When reading the address being written, old data is returned until the write edge.

Optional Feature:
- Macro: SERIAL_RX_CHECKSUM_EN.
- Defined:
  - Adds output checksum[DATA_W-1:0], the XOR of all bytes written since the last start.
  - checksum is 0 after reset or start and updates together with byte_valid.
  - In DONE it equals the XOR of the full frame.
- Undefined: no checksum port, no accumulator logic.

Decomposition:
- Shared package: DATA_W/DEPTH/ADDR_W defaults and a state enum {IDLE, RECV, DONE}.
- The transmitter reuses the same package constants so bit order and frame length stay consistent.
- One sub-module: rx_shift_reg (DATA_W-bit serial-in/parallel-out register with bit counter and done strobe).
- Memory and FSM stay in the top module.

Test Plan:
- Reset: clear=0 for 2 cycles then 1 -> all outputs 0, rd_data=0 for every rd_addr, state IDLE.
- Full frame: start, then 128 cycles with bit_en=1 streaming alternating 8'hCC/8'hAA MSB-first.
  - 16 byte_valid pulses with wr_addr 0..15.
  - frame_done=1 after the 16th byte.
  - rd_data at even addresses = 8'hCC, at odd addresses = 8'hAA.
- Gapped bits: stream 8'hA5 with bit_en low every other cycle -> one byte_valid after the 8th enabled bit, byte_out=8'hA5, mem[0]=8'hA5.
- Abort: start, 3 bytes 8'h11/8'h22/8'h33, 4 bits of a 4th byte, then start and byte 8'h44.
  - mem[0]=8'h44, mem[1]=8'h22, mem[2]=8'h33.
  - wr_addr=0 on the 8'h44 byte_valid.
- DONE hold: after a full frame, keep driving bits for 20 cycles.
  - No byte_valid pulses, memory unchanged, frame_done stays 1 until the next start.
- clear asserted mid-byte at bit 5 -> outputs and memory return to 0 asynchronously, before the next clk edge.
  - After release, a fresh start plus byte 8'hF0 gives mem[0]=8'hF0.
  - With SERIAL_RX_CHECKSUM_EN, the CC/AA frame ends with checksum=8'h00 and a frame of bytes 0..15 gives 8'h00; bytes 8'h01,8'h02,8'h04 give 8'h07.
